// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: parametrised pipeline control-register chain with per-stage stall/flush, bubble insertion and valid bits.
// Define PIPE_PERF_CNT_EN to add the stall_cycles / bubble_count performance counters.
module pipe_ctrl_chain #(
    parameter int DW = 16,
    parameter int STAGES = 4,
    parameter logic [DW-1:0] NOP_WORD = '0
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic [DW-1:0]        in_word,
    input  logic                 in_valid,
    input  logic [STAGES-1:0]    stall,
    input  logic [STAGES-1:0]    flush,
    output logic                 in_ready,
    output logic [STAGES*DW-1:0] stage_word,
    output logic [STAGES-1:0]    stage_valid
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          bubble_count
`endif
);
    logic [DW-1:0]     word_q [STAGES];
    logic [DW-1:0]     word_d [STAGES];
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] hold;
    // A stage holds if it or any stage downstream of it stalls.
    always_comb begin
        hold = '0;
        for (int i = 0; i < STAGES; i++) hold[i] = |(stall >> i);
    end
    assign in_ready = ~hold[0];
    always_comb begin
        word_d = word_q;
        valid_d = valid_q;
        if (flush[0]) begin
            word_d[0] = NOP_WORD;
            valid_d[0] = 1'b0;
        end else if (!hold[0]) begin
            word_d[0] = in_valid ? in_word : NOP_WORD;
            valid_d[0] = in_valid;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (flush[i] || (!hold[i] && hold[i-1])) begin
                word_d[i] = NOP_WORD;
                valid_d[i] = 1'b0;
            end else if (!hold[i]) begin
                word_d[i] = word_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < STAGES; i++) word_q[i] <= NOP_WORD;
            valid_q <= '0;
        end else begin
            word_q <= word_d;
            valid_q <= valid_d;
        end
    end
    always_comb begin
        stage_word = '0;
        for (int i = 0; i < STAGES; i++) stage_word[i*DW +: DW] = word_q[i];
    end
    assign stage_valid = valid_q;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q, stall_d, bubble_q, bubble_d, bubbles;
    // Bubble = stage free to move while its upstream neighbour is held, and not flushed.
    always_comb begin
        bubbles = '0;
        for (int i = 1; i < STAGES; i++)
            bubbles = bubbles + 32'(!flush[i] && !hold[i] && hold[i-1]);
        stall_d = stall_q + 32'(hold[0]);
        bubble_d = bubble_q + bubbles;
    end
    always_ff @(posedge CLK) begin
        if (CLR) begin
            stall_q <= '0;
            bubble_q <= '0;
        end else begin
            stall_q <= stall_d;
            bubble_q <= bubble_d;
        end
    end
    assign stall_cycles = stall_q;
    assign bubble_count = bubble_q;
`endif
endmodule
